// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and PC increment.
package fetch_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_RESOLVE = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd4;
    localparam logic [2:0] S_HALTED  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_FETCH   = S_FETCH,
        ST_ISSUE   = S_ISSUE,
        ST_RESOLVE = S_RESOLVE,
        ST_COMMIT  = S_COMMIT,
        ST_HALTED  = S_HALTED
    } state_t;

    // Sequential next-PC step, applied by the datapath when pc_src selects PC+4.
    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_sequencer_timeout.sv
// Instruction-memory wait counter; flags expiry on the (2**TIMEOUT_W-1)th unacknowledged FETCH cycle.
module fetch_timeout
    import fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic a_rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    // Count holds k-1 during the k-th waiting cycle, so expiry compares against 2**W-2.
    localparam logic [TIMEOUT_W-1:0] LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = inc && (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/issue/resolve/commit controller driving the PC register load and PCSrc.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TIMEOUT_W = 8,
    parameter int RETIRE_W  = 32
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                start,
    input  logic                halt_req,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic [XLEN-1:0]     instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                br_valid,
    input  logic                br_taken,
    output logic                pc_load,
    output logic                pc_src,
    output logic                busy,
    output logic                fetch_err,
    output logic [RETIRE_W-1:0] retired
);

    state_t state;
    state_t next_state;
    logic   halt_pending;
    logic   timeout_clear;
    logic   timeout_inc;
    logic   timeout_hit;

    assign timeout_clear = (next_state == ST_FETCH) && (state != ST_FETCH);
    assign timeout_inc   = (state == ST_FETCH) && !imem_ack;

    fetch_timeout #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_timeout (
        .clk    (clk),
        .a_rst  (a_rst),
        .clear  (timeout_clear),
        .inc    (timeout_inc),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A halt raised in the COMMIT cycle itself is honoured on that same exit.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)         next_state = ST_ISSUE;
                else if (timeout_hit) next_state = ST_HALTED;
            end
            ST_ISSUE:   if (instr_ready) next_state = ST_RESOLVE;
            ST_RESOLVE: if (br_valid) next_state = ST_COMMIT;
            ST_COMMIT:  next_state = (halt_pending || halt_req) ? ST_HALTED : ST_FETCH;
            ST_HALTED:  next_state = ST_HALTED;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE) && (state != ST_HALTED);

    // Handshake outputs are registered from next_state so they align with the state they belong to.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            pc_load      <= 1'b0;
            pc_src       <= 1'b0;
            instr        <= '0;
            fetch_err    <= 1'b0;
            retired      <= '0;
            halt_pending <= 1'b0;
        end else begin
            imem_req    <= (next_state == ST_FETCH);
            instr_valid <= (next_state == ST_ISSUE);
            pc_load     <= (next_state == ST_COMMIT);
            if ((state == ST_FETCH) && imem_ack) begin
                instr <= imem_rdata;
            end
            if ((state == ST_RESOLVE) && br_valid) begin
                pc_src <= br_taken;
            end
            if (next_state == ST_COMMIT) begin
                retired <= retired + RETIRE_W'(1);
            end
            if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
            if (halt_req && busy) begin
                halt_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a short imem timeout.
module tb_fetch_sequencer;

    logic        clk;
    logic        a_rst;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic        br_taken;
    logic        pc_load;
    logic        pc_src;
    logic        busy;
    logic        fetch_err;
    logic [31:0] retired;

    int testCount = 0;
    int failCount = 0;
    int loads;

    fetch_sequencer #(
        .XLEN     (32),
        .TIMEOUT_W(3),
        .RETIRE_W (32)
    ) dut (
        .clk        (clk),
        .a_rst      (a_rst),
        .start      (start),
        .halt_req   (halt_req),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .busy       (busy),
        .fetch_err  (fetch_err),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        a_rst       = 1'b0;
        start       = 1'b0;
        halt_req    = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b1;
    endtask

    initial begin
        // Reset mid-FETCH clears everything asynchronously
        applyReset();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req", imem_req, 0);
        start = 1'b1;
        stepCycle();
        checkOutput("fetch_req", imem_req, 1);
        checkOutput("fetch_busy", busy, 1);
        stepCycle();
        #2 a_rst = 1'b0;
        #1;
        checkOutput("async_req", imem_req, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_valid", instr_valid, 0);
        checkOutput("async_load", pc_load, 0);
        checkOutput("async_err", fetch_err, 0);
        checkOutput("async_ret", retired, 0);
        checkOutput("async_instr", instr, 0);
        start = 1'b0;
        stepCycle();
        checkOutput("held_busy", busy, 0);

        // Straight-line, zero-wait: one commit every 4 cycles
        applyReset();
        imem_rdata  = 32'h00500093;
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        br_valid    = 1'b1;
        br_taken    = 1'b0;
        start       = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            stepCycle();
            checkOutput($sformatf("sl_load_%0d", k), pc_load, (k % 4 == 0) ? 1 : 0);
            checkOutput($sformatf("sl_req_%0d", k), imem_req, (k % 4 == 1) ? 1 : 0);
            checkOutput($sformatf("sl_valid_%0d", k), instr_valid, (k % 4 == 2) ? 1 : 0);
            if (k == 2) checkOutput("sl_instr", instr, 32'h00500093);
            if (k % 4 == 0) begin
                checkOutput($sformatf("sl_src_%0d", k), pc_src, 0);
                checkOutput($sformatf("sl_ret_%0d", k), retired, k / 4);
            end
        end

        // Taken branch: single load with pc_src=1
        br_taken = 1'b1;
        loads = 0;
        for (int k = 13; k <= 16; k++) begin
            stepCycle();
            loads += int'(pc_load);
            if (k == 16) begin
                checkOutput("br_src", pc_src, 1);
                checkOutput("br_ret", retired, 4);
            end
        end
        checkOutput("br_loads", loads, 1);
        br_taken = 1'b0;
        stepCycle();
        checkOutput("br_next_req", imem_req, 1);

        // Decode backpressure for 5 cycles
        imem_rdata  = 32'hDEADBEEF;
        instr_ready = 1'b0;
        stepCycle();
        checkOutput("bp_instr0", instr, 32'hDEADBEEF);
        checkOutput("bp_valid0", instr_valid, 1);
        imem_rdata = 32'h0BADF00D;
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            checkOutput($sformatf("bp_instr%0d", i), instr, 32'hDEADBEEF);
            checkOutput($sformatf("bp_valid%0d", i), instr_valid, 1);
            checkOutput($sformatf("bp_load%0d", i), pc_load, 0);
        end
        instr_ready = 1'b1;
        stepCycle();
        checkOutput("bp_resolve_valid", instr_valid, 0);
        stepCycle();
        checkOutput("bp_load", pc_load, 1);
        checkOutput("bp_ret", retired, 5);

        // Halt during ISSUE: instruction still commits, then terminal
        stepCycle();
        checkOutput("h_req", imem_req, 1);
        stepCycle();
        checkOutput("h_valid", instr_valid, 1);
        halt_req = 1'b1;
        stepCycle();
        halt_req = 1'b0;
        checkOutput("h_resolve_busy", busy, 1);
        stepCycle();
        checkOutput("h_load", pc_load, 1);
        checkOutput("h_ret", retired, 6);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput($sformatf("h_busy%0d", i), busy, 0);
            checkOutput($sformatf("h_req%0d", i), imem_req, 0);
            checkOutput($sformatf("h_load%0d", i), pc_load, 0);
        end
        checkOutput("h_ret_final", retired, 6);

        // Imem timeout: 7 FETCH cycles then HALTED with fetch_err
        applyReset();
        imem_ack = 1'b0;
        start    = 1'b1;
        loads    = 0;
        for (int k = 1; k <= 7; k++) begin
            stepCycle();
            loads += int'(pc_load);
            checkOutput($sformatf("to_req_%0d", k), imem_req, 1);
            checkOutput($sformatf("to_err_%0d", k), fetch_err, 0);
        end
        stepCycle();
        loads += int'(pc_load);
        checkOutput("to_err", fetch_err, 1);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_req_off", imem_req, 0);
        imem_ack = 1'b1;
        repeat (3) begin
            stepCycle();
            loads += int'(pc_load);
        end
        checkOutput("to_err_sticky", fetch_err, 1);
        checkOutput("to_req_halted", imem_req, 0);
        checkOutput("to_ret", retired, 0);
        checkOutput("to_loads", loads, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
